fifo_fwft_stream: RTL



---
 rtl/block_ram_single_port.sv | 20 ++
 rtl/fifo_fwft_out_stage.sv | 49 ++++
 rtl/fifo_fwft_stream.sv | 92 +++++++++
 3 files changed

// File: rtl/block_ram_single_port.sv
// rtl/block_ram_single_port.sv - block RAM with registered read, one write and one read address
module block_ram_single_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/fifo_fwft_out_stage.sv
// rtl/fifo_fwft_out_stage.sv - 2-entry in-order skid that absorbs RAM read latency
module fifo_fwft_out_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  can_accept
);
    logic [1:0]            out_cnt;
    logic [1:0]            cnt_after;
    logic                  inflight;
    logic                  pop;
    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;

    assign m_valid    = (out_cnt != 2'd0);
    assign m_data     = slot0;
    assign pop        = m_valid & m_ready;
    assign cnt_after  = out_cnt - {1'b0, pop};
    // in_valid marks a read issued this cycle; its data is presented on in_data one cycle later
    assign can_accept = ({1'b0, out_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt  <= 2'd0;
            inflight <= 1'b0;
            slot0    <= '0;
            slot1    <= '0;
        end else if (flush) begin
            out_cnt  <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= in_valid;
            if (pop) slot0 <= slot1;
            // a later write to slot0 deliberately overrides the shift above
            if (inflight) begin
                if (cnt_after == 2'd0) slot0 <= in_data;
                else                   slot1 <= in_data;
            end
            out_cnt <= cnt_after + {1'b0, inflight};
        end
    end
endmodule

// File: rtl/fifo_fwft_stream.sv
// rtl/fifo_fwft_stream.sv - first-word-fall-through stream FIFO with level and thresholds
module fifo_fwft_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int AF_THRES   = DEPTH - 8,
    parameter int AE_THRES   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [$clog2(DEPTH+3)-1:0]     level,
    output logic                           almost_full,
    output logic                           almost_empty
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int LVL_W      = $clog2(DEPTH + 3);

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  ram_full;
    logic                  ram_empty;
    logic                  wr_en;
    logic                  rd_en;
    logic                  rd_hs;
    logic                  can_accept;
    logic [DATA_WIDTH-1:0] rd_data;

    assign ram_empty = (wr_ptr == rd_ptr);
    assign ram_full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                       (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign s_ready   = ~ram_full;
    assign wr_en     = s_valid & s_ready & ~flush;
    // registered pointers keep a read away from the address being written this cycle
    assign rd_en     = ~ram_empty & can_accept & ~flush;
    assign rd_hs     = m_valid & m_ready;

    assign almost_full  = (level >= LVL_W'(AF_THRES));
    assign almost_empty = (level <= LVL_W'(AE_THRES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_hs})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    block_ram_single_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    fifo_fwft_out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (rd_en),
        .in_data    (rd_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .can_accept (can_accept)
    );
endmodule
